// File: rtl/sliscp_perm_engine_if.sv
// ---------------------------------------------------------------------------
// sliscp_perm_engine_if
// Handshake bundle between the AEAD datapath and the sLiSCP-light engine.
//   in_valid / in_ready  : offer a 4*WIDTH-bit state plus a 5-bit step count
//   abort                : synchronous cancel of the job in flight
//   out_valid / out_ready: permuted state handed back to the consumer
//   busy                 : engine is iterating
// master = datapath side, slave = engine side.
// ---------------------------------------------------------------------------
interface sliscp_perm_engine_if #(
  parameter int WIDTH = 48
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4*WIDTH-1:0]   in_state;
  logic [4:0]           in_steps;
  logic                 abort;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*WIDTH-1:0]   out_state;
  logic                 busy;

  modport master (
    output in_valid, in_state, in_steps, abort, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_steps, abort, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/sliscp_perm_engine.sv
// ---------------------------------------------------------------------------
// sliscp_perm_engine
// Generic sLiSCP-light permutation core: WIDTH=48 gives sLiSCP-light-192,
// WIDTH=64 gives sLiSCP-light-256. Runs a loaded state through a runtime
// number of steps, UNROLL Simeck rounds per clock. Round and step constants
// are produced by two LFSRs stepped on the fly.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : sliscp_perm_engine_if.slave (input/output handshakes, abort, busy)
// State layout: x0 = [4W-1:3W], x1, x2, x3 = [W-1:0].
// ---------------------------------------------------------------------------
module sliscp_perm_engine #(
  parameter int WIDTH     = 48,
  parameter int UNROLL    = 1,
  parameter int MAX_STEPS = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  sliscp_perm_engine_if.slave  bus
);

  localparam int ROUNDS = (WIDTH == 64) ? 8 : 6;
  localparam int HALF   = WIDTH / 2;
  localparam int LW     = (WIDTH == 64) ? 7 : 6;

  // Bit k of an LFSR register holds sequence bit m[i+k]; the round sequence
  // starts from all ones, the step sequence from m = 0,1,0,0,...
  localparam logic [LW-1:0]    RC_SEED   = '1;
  localparam logic [LW-1:0]    SC_SEED   = LW'(2);
  localparam logic [3:0]       LAST_RC   = 4'(ROUNDS - UNROLL);
  localparam logic [4:0]       STEPS_CAP = 5'(MAX_STEPS);
  // Step constants occupy the low byte; everything above it is ones.
  localparam logic [WIDTH-1:0] SC_PAD    = {{(WIDTH-8){1'b1}}, 8'h00};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} fsm_e;

  fsm_e               r_fsm, w_fsm_nxt;
  logic [4*WIDTH-1:0] r_state, w_state_nxt;
  logic [4:0]         r_steps, r_step_ctr, w_steps_in;
  logic [3:0]         r_round_ctr;
  logic [LW-1:0]      r_rc_lfsr, r_sc_lfsr, w_rc_nxt, w_sc_nxt;
  logic [WIDTH-1:0]   w_x0, w_x1, w_x2, w_x3, w_x1_sb, w_x3_sb;
  logic [7:0]         w_sc0, w_sc1;
  logic               w_accept, w_last_round, w_last_step;

  // Two sequence bits per clock of the 2-way LFSR; feedback m[i+LW] = m[i+1]^m[i].
  function automatic logic [LW-1:0] lfsr_adv2(input logic [LW-1:0] s);
    logic [LW-1:0] t;
    t = {s[1] ^ s[0], s[LW-1:1]};
    return {t[1] ^ t[0], t[LW-1:1]};
  endfunction

  // One Simeck Feistel round: (l, r) -> (r ^ f(l) ^ (1..1 || q), l).
  function automatic logic [WIDTH-1:0] simeck_round(input logic [WIDTH-1:0] x,
                                                    input logic q);
    logic [HALF-1:0] l, r, f;
    l = x[WIDTH-1:HALF];
    r = x[HALF-1:0];
    f = (l & {l[HALF-6:0], l[HALF-1:HALF-5]}) ^ {l[HALF-2:0], l[HALF-1]};
    return {r ^ f ^ {{(HALF-1){1'b1}}, q}, l};
  endfunction

  assign {w_x0, w_x1, w_x2, w_x3} = r_state;

  // Abort blocks acceptance so a cancelled HOLD cannot start a new job.
  assign bus.in_ready  = ~bus.abort &
                         ((r_fsm == S_IDLE) | ((r_fsm == S_HOLD) & bus.out_ready));
  assign w_accept      = bus.in_valid & bus.in_ready;
  assign w_steps_in    = (bus.in_steps > STEPS_CAP) ? STEPS_CAP : bus.in_steps;
  assign w_last_round  = (r_round_ctr == LAST_RC);
  assign w_last_step   = w_last_round && ((r_step_ctr + 5'd1) == r_steps);

  assign bus.out_valid = (r_fsm == S_HOLD);
  assign bus.busy      = (r_fsm == S_RUN);
  assign bus.out_state = r_state;

  always_comb begin : round_path
    w_x1_sb  = w_x1;
    w_x3_sb  = w_x3;
    w_rc_nxt = r_rc_lfsr;
    for (int u = 0; u < UNROLL; u++) begin
      w_x1_sb  = simeck_round(w_x1_sb, w_rc_nxt[0]);
      w_x3_sb  = simeck_round(w_x3_sb, w_rc_nxt[1]);
      w_rc_nxt = lfsr_adv2(w_rc_nxt);
    end
  end

  always_comb begin : step_consts
    w_sc0    = '0;
    w_sc1    = '0;
    w_sc_nxt = r_sc_lfsr;
    for (int j = 0; j < ROUNDS; j++) begin
      w_sc0[j] = w_sc_nxt[0];
      w_sc1[j] = w_sc_nxt[1];
      w_sc_nxt = lfsr_adv2(w_sc_nxt);
    end
  end

  // On the final round of a step the mixing layer and the subblock shuffle
  // are folded into the same cycle as the last Simeck rounds.
  always_comb begin : mix_layer
    if (w_last_round)
      w_state_nxt = {w_x1_sb,
                     w_x2 ^ w_x1_sb ^ (SC_PAD | {{(WIDTH-8){1'b0}}, w_sc0}),
                     w_x3_sb,
                     w_x0 ^ w_x3_sb ^ (SC_PAD | {{(WIDTH-8){1'b0}}, w_sc1})};
    else
      w_state_nxt = {w_x0, w_x1_sb, w_x2, w_x3_sb};
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin : fsm_next
    w_fsm_nxt = r_fsm;
    unique case (r_fsm)
      S_IDLE: if (w_accept) w_fsm_nxt = (w_steps_in == 5'd0) ? S_HOLD : S_RUN;
      S_RUN: begin
        if (bus.abort)       w_fsm_nxt = S_IDLE;
        else if (w_last_step) w_fsm_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (bus.abort)          w_fsm_nxt = S_IDLE;
        else if (w_accept)      w_fsm_nxt = (w_steps_in == 5'd0) ? S_HOLD : S_RUN;
        else if (bus.out_ready) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_fsm <= S_IDLE;
    else      r_fsm <= w_fsm_nxt;
  end

  // NOTE: the state register is a plain flop vector, so it is cleared by
  // reset; that guarantees out_state reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= '0;
      r_steps     <= '0;
      r_step_ctr  <= '0;
      r_round_ctr <= '0;
      r_rc_lfsr   <= RC_SEED;
      r_sc_lfsr   <= SC_SEED;
    end else if (w_accept) begin
      r_state     <= bus.in_state;
      r_steps     <= w_steps_in;
      r_step_ctr  <= '0;
      r_round_ctr <= '0;
      r_rc_lfsr   <= RC_SEED;
      r_sc_lfsr   <= SC_SEED;
    end else if ((r_fsm == S_RUN) && !bus.abort) begin
      r_state   <= w_state_nxt;
      r_rc_lfsr <= w_rc_nxt;
      if (w_last_round) begin
        r_round_ctr <= '0;
        r_step_ctr  <= r_step_ctr + 5'd1;
        r_sc_lfsr   <= w_sc_nxt;
      end else begin
        r_round_ctr <= r_round_ctr + 4'(UNROLL);
      end
    end
  end

endmodule

// File: tb/tb_sliscp_perm_engine.sv
// ---------------------------------------------------------------------------
// tb_sliscp_perm_engine
// Directed bench for sliscp_perm_engine: one WIDTH=48/UNROLL=1 instance and
// two WIDTH=64 instances (UNROLL=2 and UNROLL=1) fed identical stimulus.
// Expected permutation results come from model_perm below, written from the
// algorithm description: explicit constant bit sequences and a step loop.
// ---------------------------------------------------------------------------
module tb_sliscp_perm_engine;

  logic clk;
  logic rst;

  sliscp_perm_engine_if #(.WIDTH(48)) if48  ();
  sliscp_perm_engine_if #(.WIDTH(64)) if64a ();
  sliscp_perm_engine_if #(.WIDTH(64)) if64b ();

  sliscp_perm_engine #(.WIDTH(48), .UNROLL(1), .MAX_STEPS(18)) u48 (
    .clk(clk), .rst(rst), .bus(if48.slave));
  sliscp_perm_engine #(.WIDTH(64), .UNROLL(2), .MAX_STEPS(18)) u64u2 (
    .clk(clk), .rst(rst), .bus(if64a.slave));
  sliscp_perm_engine #(.WIDTH(64), .UNROLL(1), .MAX_STEPS(18)) u64u1 (
    .clk(clk), .rst(rst), .bus(if64b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotl(input logic [63:0] v, input int k, input int hn);
    logic [63:0] hm;
    hm = (64'd1 << hn) - 64'd1;
    return ((v << k) | (v >> (hn - k))) & hm;
  endfunction

  function automatic logic [63:0] model_round(input logic [63:0] x, input int hn, input bit q);
    logic [63:0] hm, l, r, f;
    hm = (64'd1 << hn) - 64'd1;
    l  = (x >> hn) & hm;
    r  = x & hm;
    f  = (rotl(l, 5, hn) & l) ^ rotl(l, 1, hn);
    return (((r ^ f ^ (hm & ~64'd1) ^ 64'(q)) & hm) << hn) | l;
  endfunction

  function automatic logic [255:0] model_perm(input logic [255:0] st, input int w, input int steps);
    int          hn, lw, u;
    bit          m[512];
    bit          n[512];
    logic [63:0] x[4];
    logic [63:0] wm, sc0, sc1, t;
    logic [255:0] res;
    hn = w / 2;
    lw = (w == 64) ? 7 : 6;
    u  = (w == 64) ? 8 : 6;
    wm = (w == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << w) - 64'd1);
    for (int i = 0; i < 512; i++) begin
      if (i < lw) begin
        m[i] = 1'b1;
        n[i] = (i == 1);
      end else begin
        m[i] = m[i-lw+1] ^ m[i-lw];
        n[i] = n[i-lw+1] ^ n[i-lw];
      end
    end
    for (int k = 0; k < 4; k++) x[k] = 64'(st >> (w * (3 - k))) & wm;
    for (int s = 0; s < steps; s++) begin
      automatic int b = 2 * s * u;
      for (int r = 0; r < u; r++) begin
        x[1] = model_round(x[1], hn, m[b + 2*r]);
        x[3] = model_round(x[3], hn, m[b + 2*r + 1]);
      end
      sc0 = '0;
      sc1 = '0;
      for (int r = 0; r < u; r++) begin
        sc0[r] = n[b + 2*r];
        sc1[r] = n[b + 2*r + 1];
      end
      x[2] = x[2] ^ x[1] ^ ((wm & ~64'hff) | sc0);
      x[0] = x[0] ^ x[3] ^ ((wm & ~64'hff) | sc1);
      t = x[0]; x[0] = x[1]; x[1] = x[2]; x[2] = x[3]; x[3] = t;
    end
    res = '0;
    for (int k = 0; k < 4; k++) res = res | (256'(x[k]) << (w * (3 - k)));
    return res;
  endfunction

  // ---------------- helpers for the 48-bit instance ----------------
  // Offers one job, returns after out_valid is seen (or the budget expires).
  // lat counts rising edges after the acceptance edge.
  task automatic job48(input logic [191:0] st, input logic [4:0] steps,
                       output int lat, output logic busy0);
    @(negedge clk);
    if48.in_state = st;
    if48.in_steps = steps;
    if48.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if48.in_valid = 1'b0;
    busy0 = if48.busy;
    lat = -1;
    for (int c = 0; c < 300; c++) begin
      if (if48.out_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain48(input string tag);
    @(negedge clk);
    if48.out_ready = 1'b1;
    @(negedge clk);
    if48.out_ready = 1'b0;
    check(tag, 256'(if48.out_valid), 256'd0);
  endtask

  logic [255:0] exp_z48, exp_p48, exp_a1, exp_64;
  logic [191:0] pat_a5, pat_p;
  int           lat, lat_a, lat_b;
  logic         busy0, seen;

  initial begin
    pat_a5 = {24{8'hA5}};
    pat_p  = 192'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978;
    exp_z48 = model_perm(256'd0, 48, 18);
    exp_p48 = model_perm(256'(pat_p), 48, 18);
    exp_a1  = model_perm(256'(pat_a5), 48, 1);
    exp_64  = model_perm(256'd1, 64, 18);

    if48.in_valid = 0; if48.in_state = '0; if48.in_steps = '0; if48.abort = 0; if48.out_ready = 0;
    if64a.in_valid = 0; if64a.in_state = '0; if64a.in_steps = '0; if64a.abort = 0; if64a.out_ready = 0;
    if64b.in_valid = 0; if64b.in_state = '0; if64b.in_steps = '0; if64b.abort = 0; if64b.out_ready = 0;

    // Reset values
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_out_valid", 256'(if48.out_valid), 256'd0);
    check("rst_out_state", 256'(if48.out_state), 256'd0);
    check("rst_busy",      256'(if48.busy),      256'd0);
    check("rst_in_ready",  256'(if48.in_ready),  256'd1);
    check("rst64_in_ready", 256'(if64a.in_ready), 256'd1);
    check("rst64_state",   256'(if64b.out_state), 256'd0);
    @(negedge clk);
    rst = 1'b1;

    // All-zero 192-bit vector, 18 steps
    job48(192'd0, 5'd18, lat, busy0);
    check("z48_busy", 256'(busy0), 256'd1);
    check("z48_latency", 256'(lat), 256'd108);
    check("z48_state", 256'(if48.out_state), exp_z48);
    check("hold_in_ready", 256'(if48.in_ready), 256'd0);

    // Back-pressure: result held stable for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_valid", 256'(if48.out_valid), 256'd1);
      check("hold_state", 256'(if48.out_state), exp_z48);
    end

    // Zero-bubble: release result and accept next job on the same edge
    if48.out_ready = 1'b1;
    if48.in_valid  = 1'b1;
    if48.in_state  = pat_a5;
    if48.in_steps  = 5'd1;
    #1 check("b2b_in_ready", 256'(if48.in_ready), 256'd1);
    @(posedge clk);
    @(negedge clk);
    if48.out_ready = 1'b0;
    if48.in_valid  = 1'b0;
    check("b2b_busy", 256'(if48.busy), 256'd1);
    check("b2b_valid_low", 256'(if48.out_valid), 256'd0);
    lat = -1;
    for (int c = 0; c < 50; c++) begin
      if (if48.out_valid) begin lat = c; break; end
      @(negedge clk);
    end
    check("one_step_latency", 256'(lat), 256'd6);
    check("one_step_state", 256'(if48.out_state), exp_a1);
    drain48("one_step_drain");

    // Passthrough with zero steps
    job48(pat_a5, 5'd0, lat, busy0);
    check("pass_latency", 256'(lat), 256'd0);
    check("pass_state", 256'(if48.out_state), 256'(pat_a5));
    drain48("pass_drain");

    // Step count above the cap behaves as 18
    job48(pat_p, 5'd25, lat, busy0);
    check("cap25_latency", 256'(lat), 256'd108);
    check("cap25_state", 256'(if48.out_state), exp_p48);
    drain48("cap25_drain");
    job48(pat_p, 5'd31, lat, busy0);
    check("cap31_state", 256'(if48.out_state), exp_p48);
    drain48("cap31_drain");

    // Abort in RUN at cycle 50
    @(negedge clk);
    if48.in_state = 192'd0; if48.in_steps = 5'd18; if48.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if48.in_valid = 1'b0;
    repeat (49) @(negedge clk);
    check("abort_busy_before", 256'(if48.busy), 256'd1);
    if48.abort = 1'b1;
    @(negedge clk);
    if48.abort = 1'b0;
    #1;
    check("abort_valid", 256'(if48.out_valid), 256'd0);
    check("abort_busy", 256'(if48.busy), 256'd0);
    check("abort_in_ready", 256'(if48.in_ready), 256'd1);
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      seen = seen | if48.out_valid;
    end
    check("abort_no_result", 256'(seen), 256'd0);
    job48(192'd0, 5'd18, lat, busy0);
    check("post_abort_latency", 256'(lat), 256'd108);
    check("post_abort_state", 256'(if48.out_state), exp_z48);
    drain48("post_abort_drain");

    // Abort in HOLD beats out_ready and a simultaneous new job
    job48(pat_a5, 5'd0, lat, busy0);
    if48.abort = 1'b1; if48.out_ready = 1'b1;
    if48.in_valid = 1'b1; if48.in_state = pat_p; if48.in_steps = 5'd3;
    #1 check("abort_hold_in_ready", 256'(if48.in_ready), 256'd0);
    @(posedge clk);
    @(negedge clk);
    if48.abort = 1'b0; if48.out_ready = 1'b0; if48.in_valid = 1'b0;
    check("abort_hold_valid", 256'(if48.out_valid), 256'd0);
    check("abort_hold_busy", 256'(if48.busy), 256'd0);

    // Reset pulled at cycle 30 of a run
    @(negedge clk);
    if48.in_state = pat_p; if48.in_steps = 5'd18; if48.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if48.in_valid = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", 256'(if48.busy), 256'd0);
    check("midrst_valid", 256'(if48.out_valid), 256'd0);
    check("midrst_state", 256'(if48.out_state), 256'd0);
    check("midrst_in_ready", 256'(if48.in_ready), 256'd1);
    @(negedge clk);
    rst = 1'b1;
    job48(pat_p, 5'd18, lat, busy0);
    check("post_rst_latency", 256'(lat), 256'd108);
    check("post_rst_state", 256'(if48.out_state), exp_p48);
    drain48("post_rst_drain");

    // WIDTH=64: UNROLL=2 and UNROLL=1 on the same input
    @(negedge clk);
    if64a.in_state = 256'd1; if64a.in_steps = 5'd18; if64a.in_valid = 1'b1;
    if64b.in_state = 256'd1; if64b.in_steps = 5'd18; if64b.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if64a.in_valid = 1'b0;
    if64b.in_valid = 1'b0;
    lat_a = -1;
    lat_b = -1;
    for (int c = 0; c < 300; c++) begin
      if (lat_a < 0 && if64a.out_valid) lat_a = c;
      if (lat_b < 0 && if64b.out_valid) lat_b = c;
      if (lat_a >= 0 && lat_b >= 0) break;
      @(negedge clk);
    end
    check("w64_u2_latency", 256'(lat_a), 256'd72);
    check("w64_u1_latency", 256'(lat_b), 256'd144);
    check("w64_u2_state", if64a.out_state, exp_64);
    check("w64_u1_state", if64b.out_state, exp_64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
